// File: rtl/sipo_load_ctrl_pkg.sv
// Shared state type and default sizing for the SIPO load controller.
// SIPO_LOAD_CTRL_TIMEOUT_EN adds the ERR state used by the FETCH wait timeout.
package sipo_load_ctrl_pkg;

  localparam int SIZE_DEF    = 256;
  localparam int TIMEOUT_DEF = 1024;

`ifdef SIPO_LOAD_CTRL_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, CLR, FETCH, SHIFT, DONE, ERR} state_e;
`else
  typedef enum logic [2:0] {IDLE, CLR, FETCH, SHIFT, DONE} state_e;
`endif

endpackage

// File: rtl/sipo_load_ctrl_if.sv
// Byte stream into the SIPO load controller: valid/ready, one byte per handshake.
interface sipo_load_ctrl_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/sipo_load_ser.sv
// Byte serializer: load 8 bits, then present them MSB first, one per shift cycle.
// last_o marks the eighth shift of the current byte.
module sipo_load_ser (
  input  logic       clk,
  input  logic       rnot,
  input  logic       load_i,
  input  logic [7:0] data_i,
  input  logic       shift_i,
  output logic       msb_o,
  output logic       last_o
);

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] phase_q, phase_d;

  always_comb begin
    shreg_d = shreg_q;
    phase_d = phase_q;
    if (load_i) begin
      shreg_d = data_i;
      phase_d = 3'd0;
    end else if (shift_i) begin
      shreg_d = {shreg_q[6:0], 1'b0};
      phase_d = phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      shreg_q <= 8'd0;
      phase_q <= 3'd0;
    end else begin
      shreg_q <= shreg_d;
      phase_q <= phase_d;
    end
  end

  assign msb_o  = shreg_q[7];
  assign last_o = (phase_q == 3'd7);

endmodule

// File: rtl/sipo_load_ctrl.sv
// Frame loader: fetches SIZE/8 bytes and shifts them MSB first into an external SIPO.
// All outputs decode from registered state; SIPO_LOAD_CTRL_TIMEOUT_EN aborts a stalled FETCH.
module sipo_load_ctrl
  import sipo_load_ctrl_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rnot,
  input  logic                 start,
  output logic                 busy,
  sipo_load_ctrl_if.slave      s,
  output logic                 sipo_clear,
  output logic                 sipo_enable,
  output logic                 sipo_in,
  output logic                 done,
  output logic [$clog2(SIZE):0] bit_count,
  output logic                 timeout
);

  localparam int            CW     = $clog2(SIZE) + 1;
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  if (SIZE < 8 || (SIZE % 8) != 0 || TIMEOUT < 2) begin : g_bad_cfg
    $error("sipo_load_ctrl: SIZE must be a multiple of 8 and >= 8, TIMEOUT must be >= 2");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] bit_count_q, bit_count_d;
  logic          ser_msb;
  logic          ser_last;
  logic          hs;

  assign hs = (state_q == FETCH) && s.s_valid;

  sipo_load_ser u_ser (
    .clk     (clk),
    .rnot    (rnot),
    .load_i  (hs),
    .data_i  (s.s_data),
    .shift_i (state_q == SHIFT),
    .msb_o   (ser_msb),
    .last_o  (ser_last)
  );

`ifdef SIPO_LOAD_CTRL_TIMEOUT_EN
  localparam int            WW        = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  logic [WW-1:0] wait_q, wait_d;

  // Cleared outside FETCH, so every FETCH entry starts counting from zero.
  always_comb begin
    wait_d = '0;
    if (state_q == FETCH && !s.s_valid) wait_d = wait_q + WW'(1);
  end

  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    case (state_q)
      IDLE:  if (start) state_d = CLR;
      CLR: begin
        bit_count_d = '0;
        state_d     = FETCH;
      end
      FETCH: begin
        if (s.s_valid) state_d = SHIFT;
`ifdef SIPO_LOAD_CTRL_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) state_d = ERR;
`endif
      end
      SHIFT: begin
        bit_count_d = bit_count_q + CW'(1);
        if (ser_last) state_d = (bit_count_d == SIZE_C) ? DONE : FETCH;
      end
      DONE:  state_d = IDLE;
`ifdef SIPO_LOAD_CTRL_TIMEOUT_EN
      ERR:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      state_q     <= IDLE;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign s.s_ready   = (state_q == FETCH);
  assign sipo_enable = (state_q == SHIFT);
  assign sipo_in     = sipo_enable & ser_msb;
  assign done        = (state_q == DONE);
  assign bit_count   = bit_count_q;

`ifdef SIPO_LOAD_CTRL_TIMEOUT_EN
  assign sipo_clear = (state_q == CLR) || (state_q == ERR);
  assign timeout    = (state_q == ERR);
`else
  assign sipo_clear = (state_q == CLR);
  assign timeout    = 1'b0;
`endif

endmodule
